// File: rtl/cmp_threshold_monitor.sv
// Debounced over-threshold alarm with hysteresis, fed by a 4-bit comparator's one-hot result.
// Optional saturating sample statistics are built only when CMP_MON_STATS_EN is defined.
//
// state    | meaning
// ---------+----------------------------------------------------------
// SAFE     | alarm low, no greater run in progress
// ARMING   | alarm low, counting consecutive greater samples
// ALARM    | alarm high, no lesser run in progress
// CLEARING | alarm high, counting consecutive lesser samples
module cmp_threshold_monitor #(
    parameter int ARM_CNT = 3,
    parameter int CLR_CNT = 2,
    parameter int STAT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              lesser,
    input  logic              equal,
    input  logic              greater,
    input  logic              err_clr,
    input  logic              stat_clr,
    output logic              alarm,
    output logic              alarm_rise,
    output logic              alarm_fall,
    output logic              flag_err,
    output logic [1:0]        state,
    output logic [STAT_W-1:0] gt_count,
    output logic [STAT_W-1:0] eq_count,
    output logic [STAT_W-1:0] lt_count
);

    localparam logic [1:0] SAFE     = 2'b00;
    localparam logic [1:0] ARMING   = 2'b01;
    localparam logic [1:0] ALARM    = 2'b10;
    localparam logic [1:0] CLEARING = 2'b11;

    localparam logic [3:0] ARM_TC = 4'(ARM_CNT);
    localparam logic [3:0] CLR_TC = 4'(CLR_CNT);

    logic [2:0] flags;
    logic       accepted;
    logic       malformed;
    logic [1:0] state_nxt;
    logic [3:0] run;
    logic [3:0] run_nxt;
    logic [3:0] run_inc;
    logic       alarm_nxt;
    logic       rise_nxt;
    logic       fall_nxt;
    logic       err_nxt;

    assign flags     = {greater, equal, lesser};
    assign accepted  = in_valid & $onehot(flags);
    assign malformed = in_valid & ~$onehot(flags);
    assign run_inc   = run + 4'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= SAFE;
            run   <= 4'd0;
        end else begin
            state <= state_nxt;
            run   <= run_nxt;
        end
    end

    // Only accepted samples move the FSM; idle and malformed cycles hold state and run.
    always_comb begin
        state_nxt = state;
        run_nxt   = run;
        if (accepted) begin
            case (state)
                SAFE: begin
                    if (greater) begin
                        if (ARM_TC == 4'd1) begin
                            state_nxt = ALARM;
                            run_nxt   = 4'd0;
                        end else begin
                            state_nxt = ARMING;
                            run_nxt   = 4'd1;
                        end
                    end
                end
                ARMING: begin
                    if (greater) begin
                        if (run_inc == ARM_TC) begin
                            state_nxt = ALARM;
                            run_nxt   = 4'd0;
                        end else begin
                            run_nxt = run_inc;
                        end
                    end else begin
                        state_nxt = SAFE;
                        run_nxt   = 4'd0;
                    end
                end
                ALARM: begin
                    if (lesser) begin
                        if (CLR_TC == 4'd1) begin
                            state_nxt = SAFE;
                            run_nxt   = 4'd0;
                        end else begin
                            state_nxt = CLEARING;
                            run_nxt   = 4'd1;
                        end
                    end
                end
                default: begin
                    if (lesser) begin
                        if (run_inc == CLR_TC) begin
                            state_nxt = SAFE;
                            run_nxt   = 4'd0;
                        end else begin
                            run_nxt = run_inc;
                        end
                    end else begin
                        state_nxt = ALARM;
                        run_nxt   = 4'd0;
                    end
                end
            endcase
        end
    end

    always_comb begin
        alarm_nxt = (state_nxt == ALARM) || (state_nxt == CLEARING);
        rise_nxt  = (state_nxt == ALARM) && ((state == SAFE) || (state == ARMING));
        fall_nxt  = (state_nxt == SAFE) && ((state == ALARM) || (state == CLEARING));
        err_nxt   = flag_err;
        if (malformed) begin
            err_nxt = 1'b1;
        end else if (err_clr) begin
            err_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alarm      <= 1'b0;
            alarm_rise <= 1'b0;
            alarm_fall <= 1'b0;
            flag_err   <= 1'b0;
        end else begin
            alarm      <= alarm_nxt;
            alarm_rise <= rise_nxt;
            alarm_fall <= fall_nxt;
            flag_err   <= err_nxt;
        end
    end

`ifdef CMP_MON_STATS_EN
    localparam logic [STAT_W-1:0] ONE = STAT_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gt_count <= '0;
            eq_count <= '0;
            lt_count <= '0;
        end else if (stat_clr) begin
            gt_count <= '0;
            eq_count <= '0;
            lt_count <= '0;
        end else if (accepted) begin
            if (greater && (gt_count != '1)) gt_count <= gt_count + ONE;
            if (equal   && (eq_count != '1)) eq_count <= eq_count + ONE;
            if (lesser  && (lt_count != '1)) lt_count <= lt_count + ONE;
        end
    end
`else
    logic unused_stat_clr;
    assign unused_stat_clr = stat_clr;
    assign gt_count = '0;
    assign eq_count = '0;
    assign lt_count = '0;
`endif

endmodule

// File: tb/tb_cmp_threshold_monitor.sv
// Directed bench for cmp_threshold_monitor: a behavioural model queues expected outputs per
// sample, which are popped and checked one cycle later. Stats expectations follow CMP_MON_STATS_EN.
module tb_cmp_threshold_monitor;

    localparam int SW = 2;
`ifdef CMP_MON_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    localparam logic [2:0] G = 3'b100;
    localparam logic [2:0] E = 3'b010;
    localparam logic [2:0] L = 3'b001;

    logic clk = 1'b0;
    logic rst;
    logic in_valid, lesser, equal, greater, err_clr, stat_clr;
    logic alarm, alarm_rise, alarm_fall, flag_err;
    logic [1:0] state;
    logic [SW-1:0] gt_count, eq_count, lt_count;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [1:0]    st;
        logic          al;
        logic          ri;
        logic          fa;
        logic          er;
        logic [SW-1:0] gt;
        logic [SW-1:0] eq;
        logic [SW-1:0] lt;
    } exp_t;

    exp_t exp_q[$];

    int m_state, m_run, m_gt, m_eq, m_lt;
    bit m_rise, m_fall, m_err;

    cmp_threshold_monitor #(.ARM_CNT(3), .CLR_CNT(2), .STAT_W(SW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .lesser(lesser), .equal(equal),
        .greater(greater), .err_clr(err_clr), .stat_clr(stat_clr), .alarm(alarm),
        .alarm_rise(alarm_rise), .alarm_fall(alarm_fall), .flag_err(flag_err),
        .state(state), .gt_count(gt_count), .eq_count(eq_count), .lt_count(lt_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_run = 0; m_gt = 0; m_eq = 0; m_lt = 0;
        m_rise = 0; m_fall = 0; m_err = 0;
    endtask

    task automatic model_step(input bit v, input logic [2:0] f, input bit ec, input bit sc);
        int prev;
        bit acc, mal, g, l;
        acc  = v && ($countones(f) == 1);
        mal  = v && !acc;
        g    = f[2];
        l    = f[0];
        prev = m_state;
        if (acc) begin
            case (m_state)
                0: if (g) begin m_state = 1; m_run = 1; end
                1: if (g) begin
                       if (m_run + 1 == 3) begin m_state = 2; m_run = 0; end
                       else m_run = m_run + 1;
                   end else begin m_state = 0; m_run = 0; end
                2: if (l) begin m_state = 3; m_run = 1; end
                default: if (l) begin
                       if (m_run + 1 == 2) begin m_state = 0; m_run = 0; end
                       else m_run = m_run + 1;
                   end else begin m_state = 2; m_run = 0; end
            endcase
        end
        m_rise = (m_state == 2) && (prev < 2);
        m_fall = (m_state == 0) && (prev >= 2);
        if (mal) m_err = 1;
        else if (ec) m_err = 0;
        if (STATS) begin
            if (sc) begin m_gt = 0; m_eq = 0; m_lt = 0; end
            else if (acc) begin
                if (f[2] && m_gt < 3) m_gt++;
                if (f[1] && m_eq < 3) m_eq++;
                if (f[0] && m_lt < 3) m_lt++;
            end
        end
    endtask

    function automatic exp_t model_snapshot();
        exp_t e;
        e.st = 2'(m_state); e.al = (m_state >= 2); e.ri = m_rise; e.fa = m_fall;
        e.er = m_err; e.gt = SW'(m_gt); e.eq = SW'(m_eq); e.lt = SW'(m_lt);
        return e;
    endfunction

    task automatic compare_all(input string tag, input exp_t e);
        chk({tag, ".state"}, 32'(state), 32'(e.st));
        chk({tag, ".alarm"}, 32'(alarm), 32'(e.al));
        chk({tag, ".rise"}, 32'(alarm_rise), 32'(e.ri));
        chk({tag, ".fall"}, 32'(alarm_fall), 32'(e.fa));
        chk({tag, ".err"}, 32'(flag_err), 32'(e.er));
        chk({tag, ".gt"}, 32'(gt_count), 32'(e.gt));
        chk({tag, ".eq"}, 32'(eq_count), 32'(e.eq));
        chk({tag, ".lt"}, 32'(lt_count), 32'(e.lt));
    endtask

    task automatic step(input string tag, input bit v, input logic [2:0] f,
                        input bit ec = 1'b0, input bit sc = 1'b0);
        exp_t e;
        in_valid = v; {greater, equal, lesser} = f; err_clr = ec; stat_clr = sc;
        model_step(v, f, ec, sc);
        exp_q.push_back(model_snapshot());
        @(posedge clk); #1;
        if (exp_q.size() == 0) begin
            chk({tag, ".queue"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            compare_all(tag, e);
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 0; lesser = 0; equal = 0; greater = 0; err_clr = 0; stat_clr = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        compare_all("reset", model_snapshot());

        step("tp1_g1", 1, G);
        chk("tp1_g1_state", 32'(state), 32'h1);
        step("tp1_g2", 1, G);
        step("tp1_g3", 1, G);
        chk("tp1_alarm", 32'(alarm), 32'h1);
        chk("tp1_rise", 32'(alarm_rise), 32'h1);
        step("tp1_idle", 0, 3'b000);
        chk("tp1_rise_drop", 32'(alarm_rise), 32'h0);
        step("clr_l1", 1, L);
        step("clr_l2", 1, L);
        chk("clr_fall", 32'(alarm_fall), 32'h1);

        step("tp2_g1", 1, G);
        step("tp2_g2", 1, G);
        step("tp2_e", 1, E);
        chk("tp2_safe", 32'(state), 32'h0);
        step("tp2_g3", 1, G);
        step("tp2_g4", 1, G);
        chk("tp2_not_yet", 32'(alarm), 32'h0);
        step("tp2_g5", 1, G);
        chk("tp2_alarm", 32'(alarm), 32'h1);

        step("tp3_l1", 1, L);
        step("tp3_g", 1, G);
        step("tp3_l2", 1, L);
        chk("tp3_hold_alarm", 32'(alarm), 32'h1);
        step("tp3_l3", 1, L);
        chk("tp3_fall", 32'(alarm_fall), 32'h1);
        step("tp3_e", 1, E);

        step("gap_g1", 1, G);
        step("gap_i1", 0, G);
        step("gap_g2", 1, G);
        step("gap_i2", 0, L);
        step("gap_i3", 0, 3'b000);
        step("gap_g3", 1, G);
        step("gap_l1", 1, L);
        step("gap_i4", 0, L);
        step("gap_l2", 1, L);

        step("tp4_g1", 1, G);
        step("tp4_m011", 1, 3'b011);
        chk("tp4_err_set", 32'(flag_err), 32'h1);
        step("tp4_i1", 0, 3'b000);
        step("tp4_m000", 1, 3'b000);
        step("tp4_i2", 0, 3'b000);
        step("tp4_m111", 1, 3'b111);
        step("tp4_g2", 1, G);
        step("tp4_g3", 1, G);
        step("tp4_clr", 0, 3'b000, 1'b1);
        chk("tp4_err_cleared", 32'(flag_err), 32'h0);
        step("tp4_both", 1, 3'b110, 1'b1);
        step("tp4_clr2", 0, 3'b000, 1'b1);

        step("st_l1", 1, L);
        step("st_l2", 1, L);
        step("st_e1", 1, E);
        for (int i = 0; i < 5; i++) step($sformatf("st_g%0d", i), 1, G);
        if (STATS) chk("st_gt_sat", 32'(gt_count), 32'h3);
        step("st_clr_g", 1, G, 1'b0, 1'b1);
        step("st_e2", 1, E);
        step("st_l3", 1, E);

        // Asynchronous reset in the middle of a cycle while alarm is high.
        chk("rst_pre_alarm", 32'(alarm), 32'h1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_reset();
        compare_all("rst_async", model_snapshot());
        @(posedge clk); #1;
        chk("rst_no_fall", 32'(alarm_fall), 32'h0);
        rst = 1'b0;
        step("rst_g1", 1, G);
        step("rst_g2", 1, G);
        chk("rst_not_yet", 32'(alarm), 32'h0);
        step("rst_g3", 1, G);
        chk("rst_realarm", 32'(alarm), 32'h1);
        step("end_idle", 0, 3'b000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
